// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder with a valid/ready handshake and configurable wait states.
// It also has a program-load write port that is honoured in every state.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_instr,
  output logic [1:0]       rsp_err,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [31:0]      prog_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Address that feeds the read: comes straight from the port when there are no wait states.
  logic [31:0]      rd_addr;
  logic [1:0]       rd_err;
  logic [IDX_W-1:0] rd_idx;

  always_comb begin
    rd_addr = (state == IDLE) ? req_addr : addr_q;
    rd_err  = {|rd_addr[31:IDX_W+2], |rd_addr[1:0]};
    rd_idx  = rd_addr[IDX_W+1:2];
  end

  assign req_ready = (state == IDLE);

  // Memory has no reset, so loaded programs survive a reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // The read below samples mem before this edge's write lands, which gives read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_instr <= 32'd0;
      rsp_err   <= 2'b00;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            busy   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= rd_err;
              rsp_instr <= (rd_err != 2'b00) ? 32'd0 : mem[rd_idx];
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= rd_err;
            rsp_instr <= (rd_err != 2'b00) ? 32'd0 : mem[rd_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with WAIT_CYCLES=2 and DEPTH_WORDS=256.
// Expected values are hand-computed constants.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_err;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .IDX_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle slightly after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic progWrite(input logic [7:0] idx, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = idx;
    prog_data = data;
    step();
    prog_we = 1'b0;
  endtask

  // One complete fetch: accept, two wait edges, response, consume.
  task automatic applyStimulus(input string tag, input logic [31:0] addr,
                               input logic [31:0] exp_instr, input logic [1:0] exp_err);
    req_valid = 1'b1;
    req_addr  = addr;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_v0"}, 32'(rsp_valid), 32'd0);
    step();
    checkOutput({tag, "_v1"}, 32'(rsp_valid), 32'd0);
    step();
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_instr"}, rsp_instr, exp_instr);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput({tag, "_done"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    rsp_ready = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 8'd0;
    prog_data = 32'd0;
    step();
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_instr", rsp_instr, 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    step();

    progWrite(8'd5, 32'h2108_0004);
    progWrite(8'd0, 32'h1111_1111);
    progWrite(8'd1, 32'h2222_2222);

    applyStimulus("basic", 32'h0000_0014, 32'h2108_0004, 2'b00);
    applyStimulus("misal", 32'h0000_0016, 32'h0000_0000, 2'b01);
    applyStimulus("range", 32'h0000_0400, 32'h0000_0000, 2'b10);
    applyStimulus("both", 32'h8000_0003, 32'h0000_0000, 2'b11);

    // Stall in RESP while a new request waits.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_instr", rsp_instr, 32'h1111_1111);
      checkOutput("hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("hold_release", 32'(rsp_valid), 32'd0);
    checkOutput("hold_noacc", 32'(busy), 32'd0);
    step();
    req_valid = 1'b0;
    checkOutput("hold_acc2", 32'(busy), 32'd1);
    step();
    step();
    checkOutput("hold_instr2", rsp_instr, 32'h2222_2222);
    rsp_ready = 1'b1;
    step();

    // Back-to-back with rsp_ready held high: accepts are 4 edges apart.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    checkOutput("b2b_acc1", 32'(busy), 32'd1);
    step();
    step();
    checkOutput("b2b_instr1", rsp_instr, 32'h1111_1111);
    req_addr = 32'h4;
    step();
    checkOutput("b2b_gap", 32'(busy), 32'd0);
    step();
    req_valid = 1'b0;
    checkOutput("b2b_acc2", 32'(busy), 32'd1);
    step();
    checkOutput("b2b_v1", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("b2b_instr2", rsp_instr, 32'h2222_2222);
    step();
    rsp_ready = 1'b0;
    checkOutput("b2b_end", 32'(rsp_valid), 32'd0);

    // A write on the RESP-entry edge returns the old word.
    req_valid = 1'b1;
    req_addr  = 32'h14;
    step();
    req_valid = 1'b0;
    step();
    prog_we   = 1'b1;
    prog_addr = 8'd5;
    prog_data = 32'hDEAD_BEEF;
    step();
    prog_we = 1'b0;
    checkOutput("rbw_old", rsp_instr, 32'h2108_0004);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    applyStimulus("rbw_new", 32'h0000_0014, 32'hDEAD_BEEF, 2'b00);

    // A write during WAIT, ahead of the read edge, returns the new word.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    req_valid = 1'b0;
    progWrite(8'd0, 32'hCAFE_0000);
    step();
    checkOutput("wwait_instr", rsp_instr, 32'hCAFE_0000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset mid-WAIT drops the transaction but keeps memory.
    req_valid = 1'b1;
    req_addr  = 32'h14;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rstw_ready", 32'(req_ready), 32'd1);
    checkOutput("rstw_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rstw_stale", 32'(rsp_valid), 32'd0);
    end
    applyStimulus("rstw_mem", 32'h0000_0014, 32'hDEAD_BEEF, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
